rx_frame_filter: RTL and testbench
==================================

// Module: rx_frame_filter
// PURPOSE
// - Per-port receive stage sitting directly upstream of switchcore; one instance per port drives one
//   byte lane of switchcore rx_data/rx_ctrl (lane n = rx_data[8n+7:8n], rx_ctrl[n]).
// - Buffers each incoming frame whole, checks FCS, length and link state, and forwards only good
//   frames as a contiguous burst; bad frames are discarded so switchcore never sees them.
// PARAMETERS
// - P_ADDR_WIDTH  11    byte buffer depth = 2**P_ADDR_WIDTH; must satisfy 2**P_ADDR_WIDTH >= P_MAX_LEN
// - P_MIN_LEN     64    minimum legal frame length in bytes, FCS included
// - P_MAX_LEN     1518  maximum legal frame length in bytes, FCS included
// - P_IFG         12    idle cycles forced on out_ctrl between forwarded frames
// PORTS
// - clk        in   1   system clock; all logic on rising edge
// - reset      in   1   asynchronous, active-low reset
// - link_sync  in   1   PCS link synchronised; 0 invalidates any frame in progress
// - in_data    in   8   received byte, valid when in_ctrl=1
// - in_ctrl    in   1   frame active; high for every byte of a frame, low for >=1 cycle between frames
// - out_data   out  8   forwarded byte to switchcore lane
// - out_ctrl   out  1   forwarded frame active, same framing semantics as in_ctrl
// - ok_cnt     out  16  count of forwarded frames (see CONFIGURATION)
// - drop_cnt   out  16  count of discarded frames (see CONFIGURATION)
// BEHAVIOUR
// - Reset (reset=0): out_data=0, out_ctrl=0, ok_cnt=0, drop_cnt=0, buffer and length queue empty,
//   both FSMs idle. Asserting reset mid-frame aborts everything immediately; a partial input frame
//   is lost and out_ctrl drops to 0 with no further bytes output.
// - Storage: circular byte RAM, pointers P_ADDR_WIDTH+1 bits (wrap bit); wr_ptr, commit_ptr, rd_ptr.
//   Free = 2**P_ADDR_WIDTH - (wr_ptr - rd_ptr). Length queue: 4 entries x (P_ADDR_WIDTH+1) bits.
// - RX FSM RX_IDLE / RX_FRAME / RX_DISCARD:
//   - RX_IDLE: in_ctrl=1 and link_sync=1 -> RX_FRAME, byte written, CRC seeded. If length queue full
//     at that point -> RX_DISCARD instead (frame counted as dropped).
//   - RX_FRAME: each byte written at wr_ptr, wr_ptr++, len++, CRC updated.
//     -> RX_DISCARD on: free=0 when a byte arrives, len would exceed P_MAX_LEN, or link_sync=0.
//     in_ctrl=0 -> end check: good iff CRC residue = 0xDEBB20E3 and P_MIN_LEN<=len<=P_MAX_LEN.
//     Good: commit_ptr<=wr_ptr, push len, ok_cnt++. Bad: wr_ptr<=commit_ptr, drop_cnt++. -> RX_IDLE.
//   - RX_DISCARD: nothing written; on in_ctrl=0: wr_ptr<=commit_ptr, drop_cnt++ -> RX_IDLE.
//   - A frame dropped for any reason increments drop_cnt exactly once.
// - CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, LSB first, computed over DA..FCS, no final
//   inversion before the residue compare. FCS bytes are stored and forwarded unchanged.
// - TX FSM TX_IDLE / TX_SEND / TX_GAP:
//   - TX_IDLE: length queue non-empty -> pop len, TX_SEND.
//   - TX_SEND: one byte per cycle, out_ctrl=1, out_data=RAM[rd_ptr], rd_ptr++; after len bytes -> TX_GAP.
//   - TX_GAP: out_ctrl=0, out_data=0 for P_IFG cycles -> TX_IDLE. No backpressure from switchcore.
// - Latency: first out_ctrl=1 occurs on the 2nd rising edge after the edge sampling in_ctrl=0 for a
//   good frame with the TX FSM idle. Commit and pop in the same cycle are legal; a push while full
//   cannot occur (checked at frame start).
// - Simultaneous write and read of the buffer are legal; read always trails commit_ptr.
// CONFIGURATION
// - RX_FRAME_FILTER_STATS_EN defined: ok_cnt/drop_cnt are 16-bit registers, saturating at 0xFFFF,
//   cleared only by reset.
// - Not defined: no counter registers; ok_cnt and drop_cnt tied to 16'h0000. Filtering unchanged.
// TESTING
// - Good 64-byte frame (valid FCS) -> identical 64 bytes on out_data with out_ctrl high 64 cycles,
//   ok_cnt=1, drop_cnt=0.
// - Same frame with last FCS byte XOR 0x01 -> out_ctrl stays 0, drop_cnt=1.
// - Good-FCS 63-byte frame and 1519-byte frame -> both dropped, drop_cnt=2, no output.
// - link_sync=0 for 1 cycle at byte 30 of a 100-byte frame, then a good 64-byte frame -> first
//   dropped, second forwarded; buffer pointers equal after second frame drains.
// - Five good 64-byte frames back-to-back (1 idle cycle apart) -> five output bursts, each separated
//   by exactly 12 idle cycles; 5th frame dropped only if length queue full at its start.
// - reset=0 for 1 cycle at byte 20 of an output burst -> out_ctrl=0 same cycle, counters 0, no residue
//   output afterwards; next good frame forwards normally.
// - Build without RX_FRAME_FILTER_STATS_EN, rerun good+bad cases -> same output, counters read 0.

Source files
------------

// File: rtl/rx_frame_filter.sv
// Per-port receive filter: buffers each frame whole, forwards only good frames as a burst.
// Define RX_FRAME_FILTER_STATS_EN to build the saturating ok_cnt/drop_cnt counters.
module rx_frame_filter #(
  parameter int P_ADDR_WIDTH = 11,
  parameter int P_MIN_LEN    = 64,
  parameter int P_MAX_LEN    = 1518,
  parameter int P_IFG        = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_sync,
  input  logic [7:0]  in_data,
  input  logic        in_ctrl,
  output logic [7:0]  out_data,
  output logic        out_ctrl,
  output logic [15:0] ok_cnt,
  output logic [15:0] drop_cnt
);
  // state      | meaning
  // RX_IDLE    | waiting for in_ctrl rising
  // RX_FRAME   | storing bytes, CRC and length running
  // RX_DISCARD | frame already rejected, swallowing bytes until in_ctrl falls
  // TX_IDLE    | waiting for a committed frame length
  // TX_SEND    | streaming one byte per cycle from the buffer
  // TX_GAP     | holding out_ctrl low to form the inter-frame gap
  localparam logic [1:0] RX_IDLE    = 2'd0;
  localparam logic [1:0] RX_FRAME   = 2'd1;
  localparam logic [1:0] RX_DISCARD = 2'd2;
  localparam logic [1:0] TX_IDLE    = 2'd0;
  localparam logic [1:0] TX_SEND    = 2'd1;
  localparam logic [1:0] TX_GAP     = 2'd2;

  localparam int                    L_DEPTH    = 2 ** P_ADDR_WIDTH;
  localparam logic [P_ADDR_WIDTH:0] L_MIN      = (P_ADDR_WIDTH + 1)'(P_MIN_LEN);
  localparam logic [P_ADDR_WIDTH:0] L_MAX      = (P_ADDR_WIDTH + 1)'(P_MAX_LEN);
  localparam logic [31:0]           L_RESIDUE  = 32'hDEBB20E3;
  localparam logic [7:0]            L_GAP_LOAD = 8'(P_IFG - 1);

  function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  logic [7:0]            r_mem [L_DEPTH];
  logic [P_ADDR_WIDTH:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_len, r_tx_rem;
  logic [31:0]           r_crc;
  logic [1:0]            r_rx_state, r_tx_state;
  logic [P_ADDR_WIDTH:0] r_lq [4];
  logic [1:0]            r_lq_wp, r_lq_rp;
  logic [2:0]            r_lq_cnt;
  logic [7:0]            r_gap;

  logic        w_buf_full, w_lq_full, w_wr_en, w_good, w_end, w_push, w_pop;
  logic [31:0] w_crc_next;

  assign w_buf_full = (r_wr_ptr[P_ADDR_WIDTH] != r_rd_ptr[P_ADDR_WIDTH]) &&
                      (r_wr_ptr[P_ADDR_WIDTH-1:0] == r_rd_ptr[P_ADDR_WIDTH-1:0]);
  assign w_lq_full  = (r_lq_cnt == 3'd4);
  assign w_crc_next = f_crc8((r_rx_state == RX_IDLE) ? 32'hFFFFFFFF : r_crc, in_data);
  assign w_wr_en    = in_ctrl && link_sync && !w_buf_full &&
                      (((r_rx_state == RX_IDLE) && !w_lq_full) ||
                       ((r_rx_state == RX_FRAME) && (r_len != L_MAX)));
  assign w_good     = link_sync && (r_crc == L_RESIDUE) && (r_len >= L_MIN) && (r_len <= L_MAX);
  assign w_end      = (r_rx_state == RX_FRAME) && !in_ctrl;
  assign w_push     = w_end && w_good;
  assign w_pop      = (r_tx_state == TX_IDLE) && (r_lq_cnt != 3'd0);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[P_ADDR_WIDTH-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state   <= RX_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_len        <= '0;
      r_crc        <= 32'hFFFFFFFF;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (in_ctrl) begin
            if (w_wr_en) begin
              r_wr_ptr   <= r_wr_ptr + 1'b1;
              r_len      <= (P_ADDR_WIDTH + 1)'(1);
              r_crc      <= w_crc_next;
              r_rx_state <= RX_FRAME;
            end else begin
              r_rx_state <= RX_DISCARD;
            end
          end
        end
        RX_FRAME: begin
          if (!in_ctrl) begin
            if (w_good) r_commit_ptr <= r_wr_ptr;
            else        r_wr_ptr     <= r_commit_ptr;
            r_rx_state <= RX_IDLE;
          end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_len    <= r_len + 1'b1;
            r_crc    <= w_crc_next;
          end else begin
            r_rx_state <= RX_DISCARD;
          end
        end
        RX_DISCARD: begin
          if (!in_ctrl) begin
            r_wr_ptr   <= r_commit_ptr;
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_lq[i] <= '0;
      r_lq_wp  <= '0;
      r_lq_rp  <= '0;
      r_lq_cnt <= '0;
    end else begin
      if (w_push) begin
        r_lq[r_lq_wp] <= r_len;
        r_lq_wp       <= r_lq_wp + 2'd1;
      end
      if (w_pop) r_lq_rp <= r_lq_rp + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_lq_cnt <= r_lq_cnt + 3'd1;
        2'b01:   r_lq_cnt <= r_lq_cnt - 3'd1;
        default: r_lq_cnt <= r_lq_cnt;
      endcase
    end
  end

  // TX_IDLE spends one cycle popping, so TX_GAP runs P_IFG-1 cycles to give P_IFG idle cycles total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_rd_ptr   <= '0;
      r_tx_rem   <= '0;
      r_gap      <= '0;
      out_data   <= 8'h00;
      out_ctrl   <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          out_ctrl <= 1'b0;
          out_data <= 8'h00;
          if (w_pop) begin
            r_tx_rem   <= r_lq[r_lq_rp];
            r_tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          out_ctrl <= 1'b1;
          out_data <= r_mem[r_rd_ptr[P_ADDR_WIDTH-1:0]];
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_tx_rem <= r_tx_rem - 1'b1;
          if (r_tx_rem == (P_ADDR_WIDTH + 1)'(1)) begin
            r_gap      <= L_GAP_LOAD;
            r_tx_state <= TX_GAP;
          end
        end
        TX_GAP: begin
          out_ctrl <= 1'b0;
          out_data <= 8'h00;
          if (r_gap <= 8'd1) r_tx_state <= TX_IDLE;
          else               r_gap      <= r_gap - 8'd1;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

`ifdef RX_FRAME_FILTER_STATS_EN
  logic [15:0] r_ok_cnt, r_drop_cnt;
  logic        w_ok_evt, w_drop_evt;

  assign w_ok_evt   = w_push;
  assign w_drop_evt = (w_end && !w_good) || ((r_rx_state == RX_DISCARD) && !in_ctrl);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ok_cnt   <= 16'h0000;
      r_drop_cnt <= 16'h0000;
    end else begin
      if (w_ok_evt && (r_ok_cnt != 16'hFFFF))     r_ok_cnt   <= r_ok_cnt + 16'd1;
      if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign ok_cnt   = r_ok_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  assign ok_cnt   = 16'h0000;
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_frame_filter.sv
// Scoreboard bench for rx_frame_filter: stimulus queues expected bytes, a monitor checks output.
module tb_rx_frame_filter;
  typedef logic [7:0] bq_t [$];

`ifdef RX_FRAME_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        link_sync = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ctrl = 1'b0;
  logic [7:0]  out_data;
  logic        out_ctrl;
  logic [15:0] ok_cnt, drop_cnt;

  rx_frame_filter dut (
    .clk(clk), .reset(reset), .link_sync(link_sync), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_data(out_data), .out_ctrl(out_ctrl), .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  int checks = 0, errors = 0;
  int exp_ok = 0, exp_drop = 0;
  int burst_len = 0, idle_run = 0, gap_bursts = 0;
  bit chk_gap = 1'b0;
  logic prev_ctrl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[k][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic bq_t make_frame(input int len, input int seed);
    bq_t f;
    logic [31:0] c;
    for (int i = 0; i < len - 4; i++) f.push_back(8'((seed * 31 + i * 13) & 255));
    c = ~crc32(f);
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
    return f;
  endfunction

  task automatic send_frame(input bq_t f, input bit fwd, input int link_drop_idx);
    if (fwd) begin
      foreach (f[i]) exp_q.push_back(f[i]);
      exp_len_q.push_back(f.size());
    end
    for (int i = 0; i < f.size(); i++) begin
      @(posedge clk); #1;
      in_data   = f[i];
      in_ctrl   = 1'b1;
      link_sync = (i == link_drop_idx) ? 1'b0 : 1'b1;
    end
    @(posedge clk); #1;
    in_ctrl   = 1'b0;
    in_data   = 8'h00;
    link_sync = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 5000) ? 32'd1 : 32'd0, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_ok_cnt"},   {16'h0, ok_cnt},   STATS ? 32'(exp_ok)   : 32'd0);
    check({tag, "_drop_cnt"}, {16'h0, drop_cnt}, STATS ? 32'(exp_drop) : 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      burst_len = 0;
      idle_run  = 0;
      prev_ctrl = 1'b0;
    end else begin
      if (out_ctrl) begin
        if (!prev_ctrl && chk_gap) begin
          if (gap_bursts > 0) check("ifg_idle_cycles", idle_run, 12);
          gap_bursts++;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, expected no output at %0t", out_data, $time);
        end else begin
          check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
        burst_len++;
        idle_run = 0;
      end else begin
        if (prev_ctrl) begin
          if (exp_len_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL burst_len: got %0d, expected no burst at %0t", burst_len, $time);
          end else begin
            check("burst_len", burst_len, exp_len_q.pop_front());
          end
          burst_len = 0;
        end
        idle_run++;
        check("idle_out_data", {24'h0, out_data}, 32'd0);
      end
      prev_ctrl = out_ctrl;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    int  n;
    link_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_ctrl", {31'h0, out_ctrl}, 32'd0);
    check("rst_out_data", {24'h0, out_data}, 32'd0);
    check("rst_ok_cnt",   {16'h0, ok_cnt},   32'd0);
    check("rst_drop_cnt", {16'h0, drop_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // good 64-byte frame; out_ctrl rises on the 2nd edge after in_ctrl=0 is sampled
    f = make_frame(64, 1);
    send_frame(f, 1'b1, -1);
    @(posedge clk);
    @(negedge clk); check("latency_e0", {31'h0, out_ctrl}, 32'd0);
    @(negedge clk); check("latency_e1", {31'h0, out_ctrl}, 32'd0);
    @(negedge clk); check("latency_e2", {31'h0, out_ctrl}, 32'd1);
    exp_ok++;
    drain();
    check_cnt("good64");

    f = make_frame(64, 1);
    f[63] = f[63] ^ 8'h01;
    send_frame(f, 1'b0, -1);
    exp_drop++;
    drain();
    check_cnt("bad_fcs");

    send_frame(make_frame(63, 2), 1'b0, -1);
    send_frame(make_frame(1519, 3), 1'b0, -1);
    exp_drop += 2;
    drain();
    check_cnt("len_bounds");

    send_frame(make_frame(100, 4), 1'b0, 30);
    send_frame(make_frame(64, 5), 1'b1, -1);
    exp_drop++;
    exp_ok++;
    drain();
    check_cnt("link_drop");

    chk_gap    = 1'b1;
    gap_bursts = 0;
    for (int k = 0; k < 5; k++) send_frame(make_frame(64, 10 + k), 1'b1, -1);
    exp_ok += 5;
    drain();
    chk_gap = 1'b0;
    check("b2b_burst_count", gap_bursts, 5);
    check_cnt("b2b");

    // reset asserted while the 20th byte of a burst is on the output
    send_frame(make_frame(64, 20), 1'b1, -1);
    n = 0;
    while (burst_len < 20 && n < 1000) begin
      @(negedge clk); #2;
      n++;
    end
    check("reset_wait_timeout", (n < 1000) ? 32'd1 : 32'd0, 32'd1);
    reset = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    burst_len = 0;
    idle_run  = 0;
    prev_ctrl = 1'b0;
    exp_ok    = 0;
    exp_drop  = 0;
    #1;
    check("midburst_rst_out_ctrl", {31'h0, out_ctrl}, 32'd0);
    check("midburst_rst_ok_cnt",   {16'h0, ok_cnt},   32'd0);
    check("midburst_rst_drop_cnt", {16'h0, drop_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(make_frame(64, 21), 1'b1, -1);
    exp_ok++;
    drain();
    check_cnt("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
